// File: rtl/vc_rr_arbiter_if.sv
// Request/grant bundle between virtual-channel requesters and the round-robin arbiter.
interface vc_rr_arbiter_if #(
  parameter int NUM_VC = 4,
  parameter int IDX_W  = 2
);
  logic [NUM_VC-1:0] req;
  logic [NUM_VC-1:0] tail;
  logic              fire;
  logic [NUM_VC-1:0] grant;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;

  modport master (
    output req, tail, fire,
    input  grant, grant_valid, grant_idx
  );

  modport slave (
    input  req, tail, fire,
    output grant, grant_valid, grant_idx
  );
endinterface

// File: rtl/vc_rr_arbiter.sv
// Packet-locked round-robin arbiter: a VC owns the output from grant until its tail flit fires,
// and on release the next owner is chosen in the same cycle so packets go back to back.
module vc_rr_arbiter #(
  parameter int NUM_VC = 4,
  parameter int IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  vc_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, LOCKED} state_e;

  localparam logic [NUM_VC-1:0] ONE = {{(NUM_VC-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [NUM_VC-1:0] grant_q;
  logic [IDX_W-1:0]  grant_idx_q;
  logic              grant_valid_q;

  // First set request at or after base, wrapping modulo NUM_VC; msb flags a winner.
  function automatic logic [IDX_W:0] pick(input logic [NUM_VC-1:0] r,
                                          input logic [IDX_W-1:0]  base);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      pos = IDX_W'((int'(base) + k) % NUM_VC);
      if (!found && r[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    return {found, idx};
  endfunction

  logic [IDX_W:0]   idle_pick;
  logic [IDX_W:0]   rel_pick;
  logic [IDX_W-1:0] rel_ptr;
  logic             release_now;

  always_comb begin
    rel_ptr     = (grant_idx_q == IDX_W'(NUM_VC - 1)) ? '0 : grant_idx_q + 1'b1;
    release_now = bus.fire && bus.tail[grant_idx_q];
    idle_pick   = pick(bus.req, ptr_q);
    rel_pick    = pick(bus.req, rel_ptr);
  end

  // NOTE: every register here uses <= so all of them see the pre-edge values of each other;
  // reset covers only control state, and there is no storage array that would need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_pick[IDX_W]) begin
            state_q       <= LOCKED;
            grant_q       <= ONE << idle_pick[IDX_W-1:0];
            grant_idx_q   <= idle_pick[IDX_W-1:0];
            grant_valid_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (release_now) begin
            ptr_q <= rel_ptr;
            if (rel_pick[IDX_W]) begin
              grant_q     <= ONE << rel_pick[IDX_W-1:0];
              grant_idx_q <= rel_pick[IDX_W-1:0];
            end else begin
              state_q       <= IDLE;
              grant_q       <= '0;
              grant_idx_q   <= '0;
              grant_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Directed bench for vc_rr_arbiter with NUM_VC=4: a vector table walked in order, then a mid-packet reset sequence.
module tb_vc_rr_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vc_rr_arbiter_if #(.NUM_VC(4), .IDX_W(2)) bus ();

  vc_rr_arbiter #(.NUM_VC(4), .IDX_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [3:0] tail;
    logic       fire;
    logic [3:0] exp_grant;
    logic [1:0] exp_idx;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(string n, logic [3:0] r, logic [3:0] t, logic f,
                              logic [3:0] g, logic [1:0] i, logic v);
    vec_t x;
    x.name = n; x.req = r; x.tail = t; x.fire = f;
    x.exp_grant = g; x.exp_idx = i; x.exp_valid = v;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] g, input logic [1:0] i, input logic v);
    check({name, ".grant"}, 32'(bus.grant), 32'(g));
    check({name, ".idx"},   32'(bus.grant_idx), 32'(i));
    check({name, ".valid"}, 32'(bus.grant_valid), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = mk("first_grant",   4'b1010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1);
    vecs[1]  = mk("hold_body1",    4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1);
    vecs[2]  = mk("hold_body2",    4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1);
    vecs[3]  = mk("hold_body3",    4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1);
    vecs[4]  = mk("b2b_release",   4'b1111, 4'b0010, 1'b1, 4'b0100, 2'd2, 1'b1);
    vecs[5]  = mk("fair_to3",      4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
    vecs[6]  = mk("fair_to0",      4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    vecs[7]  = mk("fair_to1",      4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
    vecs[8]  = mk("fair_to2",      4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
    vecs[9]  = mk("fair_to3b",     4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
    vecs[10] = mk("fair_wrap0",    4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    vecs[11] = mk("other_tails",   4'b1111, 4'b1110, 1'b1, 4'b0001, 2'd0, 1'b1);
    vecs[12] = mk("move_to2",      4'b0100, 4'b0001, 1'b1, 4'b0100, 2'd2, 1'b1);
    vecs[13] = mk("owner_drops",   4'b0000, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    vecs[14] = mk("release_idle",  4'b0000, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0);
    vecs[15] = mk("fire_in_idle",  4'b0000, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    vecs[16] = mk("idle_noreq",    4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    vecs[17] = mk("idle_ptr3",     4'b1001, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1);
    vecs[18] = mk("sole_regrant",  4'b1000, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1);
    vecs[19] = mk("ptr_wrap0",     4'b1111, 4'b1000, 1'b1, 4'b0001, 2'd0, 1'b1);
    vecs[20] = mk("lock_vc2",      4'b0100, 4'b0001, 1'b1, 4'b0100, 2'd2, 1'b1);

    rst_n    = 1'b0;
    bus.req  = '0;
    bus.tail = '0;
    bus.fire = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 4'b0000, 2'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bus.req  = vecs[i].req;
      bus.tail = vecs[i].tail;
      bus.fire = vecs[i].fire;
      @(posedge clk);
      #1;
      check_outs(vecs[i].name, vecs[i].exp_grant, vecs[i].exp_idx, vecs[i].exp_valid);
    end

    // Mid-packet asynchronous reset while VC2 owns the output.
    @(negedge clk);
    bus.fire = 1'b0;
    bus.tail = '0;
    bus.req  = 4'b1100;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 4'b0000, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst_held", 4'b0000, 2'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs("post_rst_noedge", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("post_rst_grant", 4'b0100, 2'd2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_rr_arbiter.md
VC_RR_ARBITER -- requirements
Module: vc_rr_arbiter

Interface
REQ-001 Parameter NUM_VC, default 4, number of virtual-channel requesters; legal range 2..16.
REQ-002 Parameter IDX_W, default 2, grant index width; SHALL equal ceil(log2(NUM_VC)).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  NUM_VC  per-VC request, level-sensitive, bit i = VC i.
REQ-006 tail  input  NUM_VC  per-VC tail-flit flag, qualified only by fire and only for the granted VC.
REQ-007 fire  input  1  flit of granted VC accepted downstream this cycle.
REQ-008 grant  output  NUM_VC  registered one-hot grant, all-zero when idle.
REQ-009 grant_valid  output  1  registered; high iff grant is non-zero.
REQ-010 grant_idx  output  IDX_W  registered binary index of the granted VC; 0 when idle.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant held) and LOCKED (one VC owns the output until its tail flit fires).
REQ-012 Round-robin pointer ptr (IDX_W bits) SHALL mark the highest-priority VC. Priority SHALL descend ptr, ptr+1, ... wrapping modulo NUM_VC.
REQ-013 IDLE, any req bit set: next edge SHALL grant the first set req bit at or after ptr and enter LOCKED. Request-to-grant latency is 1 cycle.
REQ-014 IDLE, req all-zero: grant stays zero, state stays IDLE, ptr unchanged.
REQ-015 LOCKED: grant, grant_idx and grant_valid SHALL hold stable regardless of req changes, including deassertion of the owner's req.
REQ-016 LOCKED, fire=1 and tail[grant_idx]=1 (release):
  - ptr SHALL update to (grant_idx+1) mod NUM_VC.
  - The same edge SHALL re-arbitrate the current req using the new ptr.
  - If any req is set, grant moves to the winner and state stays LOCKED. This gives back-to-back packets with no bubble.
  - Otherwise grant clears and state goes to IDLE.
REQ-017 LOCKED, fire=1 and tail[grant_idx]=0: grant held, ptr unchanged.
REQ-018 fire in IDLE SHALL be ignored. tail bits of non-granted VCs SHALL be ignored.
REQ-019 Release when the only set req is the releasing VC SHALL re-grant that same VC.
REQ-020 Pointer wrap: release of VC NUM_VC-1 SHALL set ptr to 0.
REQ-021 grant SHALL never have more than one bit set. grant_idx SHALL always encode the set bit.
REQ-022 ptr SHALL change only on release.

Reset
REQ-023 rst_n low SHALL asynchronously force grant=0, grant_valid=0, grant_idx=0, ptr=0, state=IDLE, including mid-packet while LOCKED.
REQ-024 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with rst_n high and req non-zero.

Verification (NUM_VC=4)
REQ-025 Reset, then req=4'b1010 -> after 1 edge grant=4'b0010, grant_idx=1, grant_valid=1.
REQ-026 Holding VC1 with req=4'b1111:
  - fire=1, tail=0 for 3 cycles -> grant stays 4'b0010.
  - Then fire=1, tail=4'b0010 -> next grant=4'b0100, no idle cycle.
REQ-027 Fairness: req=4'b1111 held, one single-flit packet per grant (fire=1, tail=4'b1111 every cycle) -> grant_idx sequence 0,1,2,3,0, with wrap from 3 to 0.
REQ-028 Owner VC2 drops req while LOCKED, no fire -> grant stays 4'b0100. After fire with tail[2]=1 and req=0 -> grant=0, grant_valid=0, IDLE.
REQ-029 Sole requester VC3: release with req=4'b1000 -> grant stays 4'b1000, ptr=0.
REQ-030 rst_n pulsed low mid-packet while LOCKED on VC2 -> outputs zero immediately without a clock edge. After release of reset with req=4'b1100 -> grant=4'b0100, since ptr=0.
